// File: rtl/color_cmd_writer.sv
//==============================================================================
// Module      : color_cmd_writer
// Description : Issues the enabled nibbles of one 24-bit RGB command as
//               sequential valid/ack writes to the colour register file.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module color_cmd_writer #(
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  start_channel,
    input  logic [23:0] start_rgb,
    input  logic [5:0]  start_mask,
    output logic        valid,
    output logic [1:0]  channel,
    output logic [3:0]  address,
    output logic [3:0]  data,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRIVE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] C_TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0] C_GAP_LOAD = 3'(GAP_CYCLES - 1);

    state_t      r_state,   w_state_nxt;
    logic [2:0]  r_index,   w_index_nxt;
    logic [7:0]  r_tcnt,    w_tcnt_nxt;
    logic [2:0]  r_gcnt,    w_gcnt_nxt;
    logic [23:0] r_rgb,     w_rgb_nxt;
    logic [5:0]  r_mask,    w_mask_nxt;
    logic [1:0]  r_cmd_ch,  w_cmd_ch_nxt;
    logic        r_valid,   w_valid_nxt;
    logic [1:0]  r_channel, w_channel_nxt;
    logic [3:0]  r_address, w_address_nxt;
    logic [3:0]  r_data,    w_data_nxt;
    logic        r_busy,    w_busy_nxt;
    logic        r_done,    w_done_nxt;
    logic        r_err,     w_err_nxt;

    logic [3:0]  w_nibble;
    logic [3:0]  w_nib_addr;

    // Index 5 is the R high nibble (addr 3), index 0 the B low nibble (addr 8).
    assign w_nibble   = 4'(r_rgb >> {r_index, 2'b00});
    assign w_nib_addr = 4'd8 - {1'b0, r_index};

    always_comb begin
        w_state_nxt   = r_state;
        w_index_nxt   = r_index;
        w_tcnt_nxt    = r_tcnt;
        w_gcnt_nxt    = r_gcnt;
        w_rgb_nxt     = r_rgb;
        w_mask_nxt    = r_mask;
        w_cmd_ch_nxt  = r_cmd_ch;
        w_valid_nxt   = r_valid;
        w_channel_nxt = r_channel;
        w_address_nxt = r_address;
        w_data_nxt    = r_data;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rgb_nxt    = start_rgb;
                    w_mask_nxt   = start_mask;
                    w_cmd_ch_nxt = start_channel;
                    w_busy_nxt   = 1'b1;
                    w_index_nxt  = 3'd5;
                    w_state_nxt  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_mask[r_index]) begin
                    w_channel_nxt = r_cmd_ch;
                    w_address_nxt = w_nib_addr;
                    w_data_nxt    = w_nibble;
                    w_valid_nxt   = 1'b1;
                    w_tcnt_nxt    = 8'd0;
                    w_state_nxt   = S_DRIVE;
                end else if (r_index == 3'd0) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_index_nxt = r_index - 3'd1;
                end
            end
            S_DRIVE: begin
                // An ack on the expiry cycle still counts as a successful write.
                if (ack) begin
                    w_valid_nxt = 1'b0;
                    if (r_index == 3'd0) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_index_nxt = r_index - 3'd1;
                        w_gcnt_nxt  = C_GAP_LOAD;
                        w_state_nxt = S_GAP;
                    end
                end else if (r_tcnt == C_TO_LAST) begin
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end
            S_GAP: begin
                if (r_gcnt == 3'd0) begin
                    w_state_nxt = S_SCAN;
                end else begin
                    w_gcnt_nxt = r_gcnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_index   <= 3'd0;
            r_tcnt    <= 8'd0;
            r_gcnt    <= 3'd0;
            r_rgb     <= 24'd0;
            r_mask    <= 6'd0;
            r_cmd_ch  <= 2'd0;
            r_valid   <= 1'b0;
            r_channel <= 2'd0;
            r_address <= 4'd0;
            r_data    <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_index   <= w_index_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_rgb     <= w_rgb_nxt;
            r_mask    <= w_mask_nxt;
            r_cmd_ch  <= w_cmd_ch_nxt;
            r_valid   <= w_valid_nxt;
            r_channel <= w_channel_nxt;
            r_address <= w_address_nxt;
            r_data    <= w_data_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign valid   = r_valid;
    assign channel = r_channel;
    assign address = r_address;
    assign data    = r_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

`default_nettype wire
